hazard_control_unit: RTL

- Pipeline sequencing controller for the 5-stage MIPS-DLX core; sits beside the forwarding logic in ID.
- Decides each cycle whether PC and IF/ID advance, whether a bubble enters ID/EX, and whether IF/ID is flushed.
- Covers load-use stalls, taken-branch flushes and the hold while the multi-cycle mul/div unit runs, with timeout supervision.

---
 rtl/hazard_control_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and mul/div hold with timeout.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_COUNTER_EN.
module hazard_control_unit #(
    parameter int unsigned FLUSH_SLOTS    = 2,
    parameter int unsigned MULDIV_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        uses_rt_ID,
    input  logic [4:0]  rw_ID_EX,
    input  logic        mem_read_EX_ctrl,
    input  logic        branch_taken_EX,
    input  logic        muldiv_req_ID,
    input  logic        muldiv_done,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_bubble,
    output logic        muldiv_go,
    output logic        muldiv_error,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        FLUSH       = 2'd1,
        MULDIV_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_SLOTS - 1);
    localparam logic [7:0] WAIT_LAST    = 8'(MULDIV_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       err_set;
    logic       lu;

    assign lu = mem_read_EX_ctrl && (rw_ID_EX != 5'd0) &&
                ((rw_ID_EX == rs_ID) || (uses_rt_ID && (rw_ID_EX == rt_ID)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            flush_cnt    <= '0;
            wait_cnt     <= '0;
            muldiv_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            if (err_set)
                muldiv_error <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        wait_cnt_nxt  = wait_cnt;
        err_set       = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken_EX) begin
                    if (FLUSH_SLOTS > 1) begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_RELOAD;
                    end
                end else if (lu) begin
                    state_nxt = RUN;
                end else if (muldiv_req_ID) begin
                    state_nxt    = MULDIV_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            FLUSH: begin
                if (branch_taken_EX) begin
                    flush_cnt_nxt = FLUSH_RELOAD;
                end else begin
                    flush_cnt_nxt = flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1)
                        state_nxt = RUN;
                end
            end
            MULDIV_WAIT: begin
                // Timeout compare precedes the increment, so wait_cnt never wraps.
                if (muldiv_done) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = RUN;
                    err_set   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        muldiv_go    = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken_EX) begin
                        IF_ID_flush  = 1'b1;
                        ID_EX_bubble = 1'b1;
                    end else if (lu) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                    end else if (muldiv_req_ID) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                        muldiv_go    = 1'b1;
                    end
                end
                FLUSH: begin
                    IF_ID_flush = 1'b1;
                end
                MULDIV_WAIT: begin
                    if (!muldiv_done && (wait_cnt != WAIT_LAST)) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNTER_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (!pc_write && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
